// File: rtl/div_pkg.sv
// Shared definitions for the iterative RV32M divide unit: op and state
// encodings, the default datapath width and small op-decode helpers.
package div_pkg;

  localparam int DIV_XLEN = 32;

  // funct3[1:0] of the M-extension divide group
  typedef enum logic [1:0] {
    OP_DIV  = 2'b00,
    OP_DIVU = 2'b01,
    OP_REM  = 2'b10,
    OP_REMU = 2'b11
  } div_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_e;

  // Most negative dividend; paired with -1 it is the signed-overflow case
  localparam logic [DIV_XLEN-1:0] OVF_DIVIDEND = DIV_XLEN'(1) << (DIV_XLEN - 1);

  // DIV and REM are the signed variants (op[0] clear)
  function automatic logic is_signed_op(input logic [1:0] op);
    return ~op[0];
  endfunction

  // REM and REMU return the remainder (op[1] set)
  function automatic logic is_rem_op(input logic [1:0] op);
    return op[1];
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift the next dividend bit into the
// partial remainder and subtract the divisor if it fits.
module div_step #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rem,
  input  logic [XLEN-1:0] q,
  input  logic [XLEN-1:0] divisor_abs,
  output logic [XLEN-1:0] rem_next,
  output logic [XLEN-1:0] q_next
);

  logic [XLEN:0] shifted;
  logic [XLEN:0] diff;

  // Compare/subtract at XLEN+1 bits so the bit shifted out of rem is kept
  always_comb begin
    shifted  = {rem, q[XLEN-1]};
    diff     = shifted - {1'b0, divisor_abs};
    rem_next = shifted[XLEN-1:0];
    q_next   = {q[XLEN-2:0], 1'b0};
    if (!diff[XLEN]) begin
      rem_next = diff[XLEN-1:0];
      q_next   = {q[XLEN-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/iter_div_unit.sv
// Multi-cycle RV32M divider (DIV/DIVU/REM/REMU) for the EX stage.
// Restoring algorithm, one quotient bit per cycle; divide-by-zero and
// signed overflow resolve on the accept edge.
module iter_div_unit
  import div_pkg::*;
#(
  parameter int XLEN  = DIV_XLEN,
  parameter int CNT_W = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam logic [XLEN-1:0]  SMIN = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [CNT_W-1:0] LAST = CNT_W'(XLEN - 1);

  div_state_e       state_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             rem_op_reg;
  logic             neg_q_reg;
  logic             neg_r_reg;
  logic [XLEN-1:0]  rem_reg;
  logic [XLEN-1:0]  q_reg;
  logic [XLEN-1:0]  dvs_reg;
  logic [XLEN-1:0]  result_reg;

  logic [XLEN-1:0]  rem_next;
  logic [XLEN-1:0]  q_next;

  logic             accept;
  logic             sgn;
  logic             a_neg;
  logic             b_neg;
  logic [XLEN-1:0]  a_abs;
  logic [XLEN-1:0]  b_abs;
  logic             special;
  logic [XLEN-1:0]  special_res;
  logic [XLEN-1:0]  q_fix;
  logic [XLEN-1:0]  r_fix;

  div_step #(.XLEN(XLEN)) u_step (
    .rem         (rem_reg),
    .q           (q_reg),
    .divisor_abs (dvs_reg),
    .rem_next    (rem_next),
    .q_next      (q_next)
  );

  // Accept decode, operand magnitudes, special cases and final sign fix
  always_comb begin
    accept      = start && !flush && (state_reg == IDLE || state_reg == DONE);
    sgn         = is_signed_op(op);
    a_neg       = sgn && dividend[XLEN-1];
    b_neg       = sgn && divisor[XLEN-1];
    a_abs       = a_neg ? ('0 - dividend) : dividend;
    b_abs       = b_neg ? ('0 - divisor) : divisor;
    special     = 1'b0;
    special_res = '0;
    if (divisor == '0) begin
      special     = 1'b1;
      special_res = is_rem_op(op) ? dividend : '1;
    end else if (sgn && dividend == SMIN && divisor == '1) begin
      special     = 1'b1;
      special_res = is_rem_op(op) ? '0 : SMIN;
    end
    q_fix = neg_q_reg ? ('0 - q_next) : q_next;
    r_fix = neg_r_reg ? ('0 - rem_next) : rem_next;
  end

  // Control FSM, iteration counter and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      cnt_reg    <= '0;
      rem_op_reg <= 1'b0;
      neg_q_reg  <= 1'b0;
      neg_r_reg  <= 1'b0;
      rem_reg    <= '0;
      q_reg      <= '0;
      dvs_reg    <= '0;
      result_reg <= '0;
    end else begin
      case (state_reg)
        IDLE, DONE: begin
          if (accept) begin
            cnt_reg    <= '0;
            rem_op_reg <= is_rem_op(op);
            neg_q_reg  <= a_neg ^ b_neg;
            neg_r_reg  <= a_neg;
            rem_reg    <= '0;
            q_reg      <= a_abs;
            dvs_reg    <= b_abs;
            if (special) begin
              result_reg <= special_res;
              state_reg  <= DONE;
            end else begin
              state_reg  <= CALC;
            end
          end else begin
            state_reg <= IDLE;
          end
        end
        CALC: begin
          if (flush) begin
            state_reg <= IDLE;
          end else begin
            rem_reg <= rem_next;
            q_reg   <= q_next;
            if (cnt_reg == LAST) begin
              result_reg <= rem_op_reg ? r_fix : q_fix;
              state_reg  <= DONE;
            end else begin
              cnt_reg <= cnt_reg + 1'b1;
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign busy   = (state_reg == CALC);
  assign done   = (state_reg == DONE);
  assign result = result_reg;

endmodule

// File: tb/tb_iter_div_unit.sv
// Self-checking bench for iter_div_unit: a cycle-level behavioural model
// (plain arithmetic plus a countdown) checked every cycle, and directed
// vectors with hand-computed results and latencies.
module tb_iter_div_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        flush;
  logic [1:0]  op;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  iter_div_unit dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .op       (op),
    .dividend (dividend),
    .divisor  (divisor),
    .flush    (flush),
    .busy     (busy),
    .done     (done),
    .result   (result)
  );

  // RV32M semantics straight from the instruction definitions
  function automatic logic [31:0] ref_div(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] sq;
    logic signed [31:0] sr;
    if (b == 32'd0) return o[1] ? a : 32'hFFFF_FFFF;
    if (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return o[1] ? 32'd0 : 32'h8000_0000;
    if (!o[0]) begin
      sq = $signed(a) / $signed(b);
      sr = $signed(a) % $signed(b);
      return o[1] ? sr : sq;
    end
    return o[1] ? (a % b) : (a / b);
  endfunction

  function automatic logic is_special(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    return (b == 32'd0) || (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Behavioural model: m_left = edges until the running op completes
  int          m_left  = 0;
  logic        m_done  = 1'b0;
  logic [31:0] m_res   = 32'd0;
  logic [31:0] m_pend  = 32'd0;
  logic        m_valid = 1'b0;

  always @(posedge clk) begin : model
    int          l;
    logic        d;
    logic [31:0] r;
    logic [31:0] p;
    if (rst) begin
      m_left  <= 0;
      m_done  <= 1'b0;
      m_res   <= 32'd0;
      m_valid <= 1'b1;
    end else begin
      l = m_left;
      d = 1'b0;
      r = m_res;
      p = m_pend;
      if (flush) begin
        l = 0;
      end else if (l > 0) begin
        l = l - 1;
        if (l == 0) begin
          d = 1'b1;
          r = p;
        end
      end else if (start) begin
        p = ref_div(op, dividend, divisor);
        if (is_special(op, dividend, divisor)) begin
          d = 1'b1;
          r = p;
        end else begin
          l = 32;
        end
      end
      m_left <= l;
      m_done <= d;
      m_res  <= r;
      m_pend <= p;
    end
  end

  // Every-cycle comparison of the DUT against the model
  always @(negedge clk) begin
    if (m_valid) begin
      check("cyc busy", {31'd0, busy}, {31'd0, m_left > 0});
      check("cyc done", {31'd0, done}, {31'd0, m_done});
      check("cyc result", result, m_res);
    end
  end

  // Issue one op at the current cycle (cycle 0) and wait for done
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input int lat, input string name);
    int n;
    start    = 1'b1;
    op       = o;
    dividend = a;
    divisor  = b;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
      if (n == 1) begin
        start    = 1'b0;
        op       = 2'($urandom);
        dividend = $urandom;
        divisor  = $urandom;
      end
    end while (!done && n < 80);
    check({name, " result"}, result, exp);
    check({name, " latency"}, n, lat);
    $display("op=%0d a=%h b=%h result=%h done_cycle=%0d", o, a, b, result, n);
  endtask

  initial begin
    int n;
    rst = 1'b1; start = 1'b0; flush = 1'b0; op = 2'd0; dividend = 32'd0; divisor = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("reset busy", {31'd0, busy}, 32'd0);
    check("reset done", {31'd0, done}, 32'd0);
    check("reset result", result, 32'd0);

    // Normal path, 33-cycle latency; consecutive calls also exercise start in DONE
    run_op(2'b01, 32'd100, 32'd7, 32'd14, 33, "DIVU 100/7");
    run_op(2'b11, 32'd100, 32'd7, 32'd2, 33, "REMU 100/7");
    run_op(2'b00, 32'hFFFF_FFEC, 32'd3, 32'hFFFF_FFFA, 33, "DIV -20/3");
    run_op(2'b10, 32'hFFFF_FFEC, 32'd3, 32'hFFFF_FFFE, 33, "REM -20/3");
    run_op(2'b10, 32'd20, 32'hFFFF_FFFD, 32'd2, 33, "REM 20/-3");
    run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'd1, 33, "DIVU big/big");
    run_op(2'b11, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 33, "REMU big/msb");

    // Special cases, latency 1
    run_op(2'b01, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, "DIVU 5/0");
    run_op(2'b10, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 1, "REM -5/0");
    run_op(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, "DIV ovf");
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1, "REM ovf");

    // Back-to-back: second start held during DONE, no idle gap
    run_op(2'b01, 32'd100, 32'd7, 32'd14, 33, "b2b first");
    run_op(2'b01, 32'd9, 32'd2, 32'd4, 33, "b2b second");

    // Flush together with start at CALC cycle 10: abort, result unchanged
    @(posedge clk); #1;
    start = 1'b1; op = 2'b01; dividend = 32'd1000; divisor = 32'd3;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    flush = 1'b1; start = 1'b1; dividend = 32'd50; divisor = 32'd5;
    @(posedge clk); #1;
    flush = 1'b0; start = 1'b0;
    check("flush busy", {31'd0, busy}, 32'd0);
    check("flush done", {31'd0, done}, 32'd0);
    n = 0;
    repeat (40) begin @(posedge clk); #1; if (done) n++; end
    check("flush no done", n, 32'd0);
    check("flush result", result, 32'd4);
    $display("flush at calc cycle 10: result=%h done_pulses=%0d", result, n);

    // Reset in the middle of CALC
    @(posedge clk); #1;
    start = 1'b1; op = 2'b00; dividend = 32'hFFFF_FFEC; divisor = 32'd3;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst busy", {31'd0, busy}, 32'd0);
    check("midrst done", {31'd0, done}, 32'd0);
    check("midrst result", result, 32'd0);
    $display("reset mid-calc: busy=%0d done=%0d result=%h", busy, done, result);

    // start during CALC with other operands is ignored
    @(posedge clk); #1;
    start = 1'b1; op = 2'b01; dividend = 32'd100; divisor = 32'd7;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
      start = (n == 5);
      if (n == 5) begin op = 2'b01; dividend = 32'd9; divisor = 32'd2; end
    end while (!done && n < 80);
    start = 1'b0;
    check("ignore start result", result, 32'd14);
    check("ignore start latency", n, 32'd33);
    $display("start during calc ignored: result=%h done_cycle=%0d", result, n);

    repeat (3) @(posedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
